// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scanner: binary-coded modulation, clock-enable slot timing, processor pixel port.
// Define HUB75_DOUBLE_BUFFER_EN for front/back frame buffers exchanged at frame end on request.
module hub75_bcm_driver #(
  parameter int NUM_COLS   = 64,
  parameter int NUM_ROWS   = 64,
  parameter int BIT_DEPTH  = 4,
  parameter int CLK_DIV    = 10,
  parameter int INIT_DELAY = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 wr_en,
  input  logic [$clog2(NUM_COLS*NUM_ROWS)-1:0] wr_addr,
  input  logic [3*BIT_DEPTH-1:0]               wr_data,
  input  logic                                 swap_req,
  output logic                                 swap_ack,
  output logic                                 clk_screen,
  output logic                                 R0,
  output logic                                 G0,
  output logic                                 B0,
  output logic                                 R1,
  output logic                                 G1,
  output logic                                 B1,
  output logic                                 latch,
  output logic                                 blank,
  output logic [$clog2(NUM_ROWS/2)-1:0]        row
);
  localparam int ADDR_W = $clog2(NUM_COLS*NUM_ROWS);
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int ROW_W  = $clog2(NUM_ROWS/2);
  localparam int BANK_W = ADDR_W - 1;
  localparam int DW     = 3*BIT_DEPTH;
  localparam int PL_W   = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int DLY_W  = $clog2((INIT_DELAY << (BIT_DEPTH-1)) + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, SHOW, NEXT} state_t;

  state_t             state, state_d;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [COL_W-1:0]   col, col_d;
  logic [DLY_W-1:0]   dly, dly_d, show_len;
  logic [PL_W-1:0]    plane, plane_d;
  logic [ROW_W-1:0]   row_d;
  logic               last_col, last_show, last_plane, frame_end;
  logic               swap_ack_d;
  logic [DW-1:0]      top_q, bot_q;
  logic [BIT_DEPTH-1:0] top_r, top_g, top_b, bot_r, bot_g, bot_b;

  // Slot prescaler: free-running, one tick per CLK_DIV cycles.
  assign tick = (div_cnt == DIV_W'(CLK_DIV-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  assign show_len   = DLY_W'(INIT_DELAY) << plane;
  assign last_col   = (col == COL_W'(NUM_COLS-1));
  assign last_show  = (dly == show_len - 1'b1);
  assign last_plane = (plane == PL_W'(BIT_DEPTH-1));
  assign frame_end  = tick && (state == NEXT) && last_plane && (row == ROW_W'(NUM_ROWS/2-1));

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // FSM next state; enable is only sampled at slot boundaries out of IDLE and NEXT
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (tick && enable)    state_d = SHIFT;
      SHIFT: if (tick && last_col)  state_d = LATCH;
      LATCH: if (tick)              state_d = SHOW;
      SHOW:  if (tick && last_show) state_d = NEXT;
      NEXT:  if (tick)              state_d = enable ? SHIFT : IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Scan counters; their next values also address the pixel read one cycle ahead.
  always_comb begin
    col_d   = col;
    dly_d   = dly;
    plane_d = plane;
    row_d   = row;
    if (tick) begin
      case (state)
        SHIFT: col_d = col + 1'b1;
        SHOW:  dly_d = last_show ? '0 : dly + 1'b1;
        NEXT: begin
          plane_d = last_plane ? '0 : plane + 1'b1;
          if (last_plane) row_d = row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      dly      <= '0;
      plane    <= '0;
      row      <= '0;
      swap_ack <= 1'b0;
    end else begin
      col      <= col_d;
      dly      <= dly_d;
      plane    <= plane_d;
      row      <= row_d;
      swap_ack <= swap_ack_d;
    end
  end

`ifdef HUB75_DOUBLE_BUFFER_EN
  localparam int MEM_W = BANK_W + 1;
  logic             front, front_d, pend, do_swap;
  logic [MEM_W-1:0] wr_idx, rd_idx;

  assign do_swap    = frame_end & pend;
  assign front_d    = front ^ do_swap;
  assign swap_ack_d = do_swap;
  assign wr_idx     = {~front, wr_addr[BANK_W-1:0]};
  assign rd_idx     = {front_d, row_d, col_d};

  // A request landing on the swap cycle itself survives into the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front <= 1'b0;
      pend  <= 1'b0;
    end else begin
      front <= front_d;
      pend  <= swap_req | (pend & ~do_swap);
    end
  end
`else
  localparam int MEM_W = BANK_W;
  logic             unused_swap_req;
  logic [MEM_W-1:0] wr_idx, rd_idx;

  assign unused_swap_req = swap_req;
  assign swap_ack_d      = frame_end;
  assign wr_idx          = wr_addr[BANK_W-1:0];
  assign rd_idx          = {row_d, col_d};
`endif

  logic [DW-1:0] top_mem [2**MEM_W];
  logic [DW-1:0] bot_mem [2**MEM_W];

  // Read-first synchronous RAMs, both halves read at the same column.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_addr[ADDR_W-1]) top_mem[wr_idx] <= wr_data;
    if (wr_en &&  wr_addr[ADDR_W-1]) bot_mem[wr_idx] <= wr_data;
    top_q <= top_mem[rd_idx];
    bot_q <= bot_mem[rd_idx];
  end

  assign {top_r, top_g, top_b} = top_q;
  assign {bot_r, bot_g, bot_b} = bot_q;

  // FSM outputs
  always_comb begin
    clk_screen = 1'b0;
    latch      = 1'b0;
    blank      = 1'b1;
    {R0, G0, B0, R1, G1, B1} = '0;
    case (state)
      SHIFT: begin
        clk_screen = (div_cnt >= DIV_W'(CLK_DIV/2));
        R0 = top_r[plane];
        G0 = top_g[plane];
        B0 = top_b[plane];
        R1 = bot_r[plane];
        G1 = bot_g[plane];
        B1 = bot_b[plane];
      end
      LATCH:   latch = 1'b1;
      SHOW:    blank = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver at 4x4 panel, 2-bit depth, CLK_DIV=2, INIT_DELAY=2.
module tb_hub75_bcm_driver;
  localparam int TLEN = 150;

  logic       clk = 1'b0, reset = 1'b0, enable = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       swap_ack, clk_screen, R0, G0, B0, R1, G1, B1, latch, blank;
  logic [0:0] row;

  int n_chk = 0, n_fail = 0;
  logic cs_t [TLEN], r0_t [TLEN], b0_t [TLEN], g1_t [TLEN];
  logic lat_t [TLEN], blk_t [TLEN], row_t [TLEN], ack_t [TLEN];

  always #5 clk = ~clk;

  hub75_bcm_driver #(.NUM_COLS(4), .NUM_ROWS(4), .BIT_DEPTH(2), .CLK_DIV(2), .INIT_DELAY(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack), .clk_screen(clk_screen),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .latch(latch), .blank(blank), .row(row)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_le(input string tag, input int got, input int lim);
    n_chk++;
    assert (got <= lim) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected <= %0d", tag, got, lim);
    end
  endtask

  task automatic sample(input int t);
    cs_t[t] = clk_screen; r0_t[t] = R0; b0_t[t] = B0; g1_t[t] = G1;
    lat_t[t] = latch; blk_t[t] = blank; row_t[t] = row[0]; ack_t[t] = swap_ack;
  endtask

  task automatic wr(input int a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int n, a, b, c;
    // Reset phase; memory loads while held in reset.
    step(); step(); step();
    for (int i = 0; i < 16; i++)
      wr(i, (i == 2) ? 6'b11_00_01 : (i == 9) ? 6'b00_10_00 : 6'b0);
    chk("rst_blank", blank, 1);
    chk("rst_latch", latch, 0);
    chk("rst_clk_screen", clk_screen, 0);
    chk("rst_row", row, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_rgb", {R0, G0, B0, R1, G1, B1}, 0);

    reset = 1'b1; enable = 1'b1;
`ifdef HUB75_DOUBLE_BUFFER_EN
    swap_req = 1'b1;
`endif
    n = 0;
    do begin
      step(); n++;
      swap_req = 1'b0;
`ifndef HUB75_DOUBLE_BUFFER_EN
      if (n >= 2 && n - 2 < TLEN) sample(n - 2);
`endif
    end while (!clk_screen && n < 10);
    chk_le("first_rise", n, 3);

`ifdef HUB75_DOUBLE_BUFFER_EN
    n = 0;
    while (!swap_ack && n < 200) begin step(); n++; end
    chk("init_swap_ack", swap_ack, 1);
    sample(0);
    for (int t = 1; t < TLEN; t++) begin step(); sample(t); end
`else
    for (int t = 2; t < TLEN; t++) begin step(); sample(t); end
`endif

    // Plane 0 of row 0: t=0..15
    a = 0;
    for (int t = 1; t < 16; t++) if (cs_t[t] && !cs_t[t-1]) a++;
    chk("p0_clk_rises", a, 4);
    a = 0; b = 0; c = 0;
    for (int t = 0; t < 16; t++) begin a += r0_t[t]; b += b0_t[t]; c += !blk_t[t]; end
    chk("p0_r0_ones", a, 2);
    chk("p0_b0_ones", b, 2);
    chk("p0_r0_col2", r0_t[4] & r0_t[5], 1);
    chk("p0_b0_col2", b0_t[4] & b0_t[5], 1);
    chk("p0_show_cycles", c, 4);
    a = 0; b = 0;
    for (int t = 0; t < 16; t++) a += lat_t[t];
    for (int t = 8; t < 16; t++) b += cs_t[t];
    chk("p0_latch_cycles", a, 2);
    chk("p0_latch_slot", lat_t[8] & lat_t[9], 1);
    chk("p0_clk_idle_outside_shift", b, 0);
    a = 0;
    for (int t = 0; t < 16; t++) a += g1_t[t];
    chk("p0_g1_ones", a, 0);

    // Plane 1 of row 0: t=16..35
    a = 0; b = 0; c = 0;
    for (int t = 16; t < 36; t++) begin a += r0_t[t]; b += b0_t[t]; c += !blk_t[t]; end
    chk("p1_r0_ones", a, 2);
    chk("p1_r0_col2", r0_t[20] & r0_t[21], 1);
    chk("p1_b0_ones", b, 0);
    chk("p1_show_cycles", c, 8);
    chk("p1_g1_col1", g1_t[18] & g1_t[19], 1);

    chk("row_before_inc", row_t[35], 0);
    chk("row_after_inc", row_t[36], 1);
    chk("row_end_frame", row_t[71], 1);
    chk("row_wrap", row_t[72], 0);
    a = 0;
    for (int t = 36; t < 72; t++) a += r0_t[t];
    chk("row1_r0_ones", a, 0);
`ifdef HUB75_DOUBLE_BUFFER_EN
    chk("ack_swap_frame", ack_t[0], 1);
    chk("ack_no_pending", ack_t[72], 0);
`else
    chk("ack_before_end", ack_t[71], 0);
    chk("ack_frame_end", ack_t[72], 1);
    chk("ack_one_cycle", ack_t[73], 0);
    chk("ack_second_frame", ack_t[144], 1);
`endif

    // Enable dropped mid-SHIFT of plane 0: finish through NEXT, then idle.
    enable = 1'b0;
    a = 0; b = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      a += !blank;
      if (i >= 20) b += clk_screen + latch + !blank;
    end
    chk("dis_show_cycles", a, 4);
    chk("dis_idle_activity", b, 0);
    chk("dis_row_held", row, 0);

    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (!clk_screen && n < 10);
    chk_le("reen_first_rise", n, 3);
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 19; i++) begin
      a += R0; b += B0; c += !blank;
      step();
    end
    chk("reen_p1_r0_ones", a, 2);
    chk("reen_p1_b0_ones", b, 0);
    chk("reen_p1_show_cycles", c, 8);
    chk("reen_row_inc", row, 1);

`ifdef HUB75_DOUBLE_BUFFER_EN
    a = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 6'h3F; swap_req = (i == 0);
      step();
      a += R0 + G1;
    end
    wr_en = 1'b0; swap_req = 1'b0;
    n = 0;
    while (!swap_ack && n < 200) begin a += R0 + G1; step(); n++; end
    chk("swap_old_data_kept", a, 0);
    chk("swap_ack_seen", swap_ack, 1);
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 72; i++) begin
      a += R0; b += G1; c += swap_ack;
      step();
    end
    chk("swap_new_r0", a, 32);
    chk("swap_new_g1", b, 32);
    chk("swap_ack_pulses", c, 1);
`else
    n = 0;
    while (!swap_ack && n < 200) begin step(); n++; end
    chk("ack_seen", swap_ack, 1);
    step();
    chk("ack_single_cycle", swap_ack, 0);
    n = 1;
    while (!swap_ack && n < 200) begin step(); n++; end
    chk("ack_period", n, 72);
`endif

    // Asynchronous reset during SHOW of row 1.
    n = 0;
    while (!(row == 1'b1 && !blank) && n < 200) begin step(); n++; end
    chk("rst_reached_show", !blank, 1);
    reset = 1'b0;
    #1;
    chk("arst_blank", blank, 1);
    chk("arst_latch", latch, 0);
    chk("arst_clk_screen", clk_screen, 0);
    chk("arst_row", row, 0);
    step(); step();
    reset = 1'b1;
    n = 0;
    do begin step(); n++; end while (!clk_screen && n < 10);
    chk_le("arst_first_rise", n, 3);
    chk("arst_row_after", row, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
